// File: rtl/orion_types.sv
// Shared types for the issue-control slice: FSM state encoding and register-file size.
package orion_types;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        ISSUE_RUN,
        ISSUE_STALL,
        ISSUE_HUNG
    } issue_state_t;

endpackage

// File: rtl/pend_counter.sv
// Per-register in-flight writer counter: up/down, clamped at zero and at all-ones.
module pend_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full
);

    logic [CNT_W-1:0] count_reg;

    // Simultaneous inc and dec cancel; each direction is blocked at its limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (inc && !dec && !full) begin
            count_reg <= count_reg + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign zero = (count_reg == '0);
    assign full = &count_reg;

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue control: RAW/WAW hazard stall, stall counting, stall watchdog.
module issue_scoreboard
    import orion_types::*;
#(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_s_i,
    input  logic [REG_W-1:0] id_rs2_s_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [REG_W-1:0] id_rd_s_i,
    input  logic             id_rd_we_i,
    input  logic             flush_i,
    input  logic             ret_valid_i,
    input  logic [REG_W-1:0] ret_rd_s_i,
    output logic             id_stall_o,
    output logic             id_issue_o,
    output logic [31:0]      stall_cnt_o,
    output logic             hang_o
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    logic [NUM_REGS-1:0] pend_zero;
    logic [NUM_REGS-1:0] pend_full;
    logic [NUM_REGS-1:1] inc_vec;
    logic [NUM_REGS-1:1] dec_vec;

    logic src_hazard;
    logic dst_hazard;

    issue_state_t      state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next, wait_inc;
    logic [31:0]       stall_cnt_reg;

    // x0 is hardwired: never pending, never saturated.
    assign pend_zero[0] = 1'b1;
    assign pend_full[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_pend
            assign inc_vec[gi] = id_issue_o && id_rd_we_i && (id_rd_s_i == REG_W'(gi));
            assign dec_vec[gi] = ret_valid_i && (ret_rd_s_i == REG_W'(gi));

            pend_counter #(
                .CNT_W (CNT_W)
            ) u_pend (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .inc    (inc_vec[gi]),
                .dec    (dec_vec[gi]),
                .zero   (pend_zero[gi]),
                .full   (pend_full[gi])
            );
        end
    endgenerate

    // Hazards look only at registered counts, so a same-cycle retire does not unblock.
    always_comb begin
        src_hazard = (id_rs1_used_i && (id_rs1_s_i != '0) && !pend_zero[id_rs1_s_i])
                  || (id_rs2_used_i && (id_rs2_s_i != '0) && !pend_zero[id_rs2_s_i]);
        dst_hazard = id_rd_we_i && (id_rd_s_i != '0) && pend_full[id_rd_s_i];
        id_stall_o = id_valid_i && !flush_i && (src_hazard || dst_hazard);
        id_issue_o = id_valid_i && !flush_i && !id_stall_o;
    end

    // Watchdog next-state: the wait counter counts STALL cycles after the first stall cycle,
    // so reaching TIMEOUT-1 on an edge means TIMEOUT consecutive stall cycles have elapsed.
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        wait_inc   = wait_reg + WAIT_W'(1);
        case (state_reg)
            ISSUE_RUN: begin
                wait_next = '0;
                if (id_stall_o) begin
                    state_next = ISSUE_STALL;
                end
            end
            ISSUE_STALL: begin
                if (!id_stall_o) begin
                    state_next = ISSUE_RUN;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_inc;
                    if (wait_inc == WAIT_W'(TIMEOUT - 1)) begin
                        state_next = ISSUE_HUNG;
                    end
                end
            end
            ISSUE_HUNG: begin
                state_next = ISSUE_HUNG;
            end
            default: begin
                state_next = ISSUE_RUN;
                wait_next  = '0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ISSUE_RUN;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // Saturating performance counter of stall cycles, independent of FSM state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_reg <= '0;
        end else if (id_stall_o && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign hang_o      = (state_reg == ISSUE_HUNG);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed + randomized bench for issue_scoreboard against a per-register count model.
module tb_issue_scoreboard;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 64;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        u1 = 1'b0;
    logic        u2 = 1'b0;
    logic [4:0]  rd = '0;
    logic        we = 1'b0;
    logic        flush = 1'b0;
    logic        ret_valid = 1'b0;
    logic [4:0]  ret_rd = '0;
    logic        id_stall;
    logic        id_issue;
    logic [31:0] stall_cnt;
    logic        hang;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // Reference model: in-flight writers per register, stall count, consecutive-stall run.
    int          pend_m [32];
    logic [31:0] stall_cnt_m;
    int          consec_m;
    logic        hang_m;

    always #5 clk = ~clk;

    issue_scoreboard #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .id_valid_i    (id_valid),
        .id_rs1_s_i    (rs1),
        .id_rs2_s_i    (rs2),
        .id_rs1_used_i (u1),
        .id_rs2_used_i (u2),
        .id_rd_s_i     (rd),
        .id_rd_we_i    (we),
        .flush_i       (flush),
        .ret_valid_i   (ret_valid),
        .ret_rd_s_i    (ret_rd),
        .id_stall_o    (id_stall),
        .id_issue_o    (id_issue),
        .stall_cnt_o   (stall_cnt),
        .hang_o        (hang)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) pend_m[r] = 0;
        stall_cnt_m = '0;
        consec_m    = 0;
        hang_m      = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [4:0] r1, input bit a1, input logic [4:0] r2,
                         input bit a2, input logic [4:0] d, input bit w, input bit fl,
                         input bit rv, input logic [4:0] rr);
        id_valid = v; rs1 = r1; u1 = a1; rs2 = r2; u2 = a2;
        rd = d; we = w; flush = fl; ret_valid = rv; ret_rd = rr;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance model with the edge.
    task automatic cycle(output logic so, output logic io);
        bit es, ei, inc, dec;
        #2;
        es = id_valid && !flush &&
             ((u1 && rs1 != 0 && pend_m[rs1] != 0) ||
              (u2 && rs2 != 0 && pend_m[rs2] != 0) ||
              (we && rd != 0 && pend_m[rd] == MAXC));
        ei = id_valid && !flush && !es;
        so = id_stall;
        io = id_issue;
        $display("cyc %0d v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b fl=%0b ret=%0b/%0d -> stall=%0b issue=%0b cnt=%0d hang=%0b",
                 cyc, id_valid, rs1, u1, rs2, u2, rd, we, flush, ret_valid, ret_rd,
                 id_stall, id_issue, stall_cnt, hang);
        check("stall", {31'b0, so}, {31'b0, es});
        check("issue", {31'b0, io}, {31'b0, ei});
        check("stall_cnt", stall_cnt, stall_cnt_m);
        check("hang", {31'b0, hang}, {31'b0, hang_m});
        @(posedge clk);
        cyc++;
        inc = ei && we && rd != 0;
        dec = ret_valid && ret_rd != 0;
        if (!(inc && dec && rd == ret_rd)) begin
            if (inc && pend_m[rd] < MAXC) pend_m[rd]++;
            if (dec && pend_m[ret_rd] > 0) pend_m[ret_rd]--;
        end
        if (es) begin
            if (stall_cnt_m != 32'hFFFF_FFFF) stall_cnt_m++;
            consec_m++;
        end else begin
            consec_m = 0;
        end
        if (consec_m >= TIMEOUT) hang_m = 1'b1;
        #1;
    endtask

    // Asynchronous reset pulse, asserted away from the clock edge.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_ni = 1'b0;
        #1;
        check("rst_hang", {31'b0, hang}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_stall", {31'b0, id_stall}, 32'd0);
        check("rst_issue", {31'b0, id_issue}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        logic s, i;
        logic [4:0] r_a, r_b, r_d, r_r;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Back-to-back RAW on x5, retire in the third stall cycle.
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cycle(s, i);
        check("raw_wr_issue", {31'b0, i}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 5, 1, 0, 0, 0, 0, 0, k == 2, 5); cycle(s, i);
            check("raw_stall", {31'b0, s}, 32'd1);
            check("raw_hold", {31'b0, i}, 32'd0);
        end
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); cycle(s, i);
        check("raw_issue_after_ret", {31'b0, i}, 32'd1);
        check("raw_stall_cnt", stall_cnt, 32'd3);

        // x0 never pending; unused source ignored.
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle(s, i);
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0); cycle(s, i);
        check("x0_no_stall", {31'b0, s}, 32'd0);
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cycle(s, i);
        drive(1, 0, 0, 5, 0, 0, 0, 0, 0, 0); cycle(s, i);
        check("unused_no_stall", {31'b0, s}, 32'd0);
        check("unused_issue", {31'b0, i}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5); cycle(s, i);

        // Saturation of x7 at three writers.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle(s, i);
            check("sat_wr_issue", {31'b0, i}, 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle(s, i);
            check("sat_stall", {31'b0, s}, 32'd1);
        end
        drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 7); cycle(s, i);
        check("sat_stall_ret_cycle", {31'b0, s}, 32'd1);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle(s, i);
        check("sat_issue_after_ret", {31'b0, i}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7); cycle(s, i);
        end

        // Simultaneous issue+retire on x9, then retire at zero.
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); cycle(s, i);
        drive(1, 0, 0, 0, 0, 9, 1, 0, 1, 9); cycle(s, i);
        check("sim_issue", {31'b0, i}, 32'd1);
        drive(1, 9, 1, 0, 0, 0, 0, 0, 1, 9); cycle(s, i);
        check("sim_reader_stall", {31'b0, s}, 32'd1);
        drive(1, 9, 1, 0, 0, 0, 0, 0, 1, 9); cycle(s, i);
        check("sim_reader_issue", {31'b0, i}, 32'd1);
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); cycle(s, i);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9); cycle(s, i);
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 0); cycle(s, i);
        check("underflow_guard", {31'b0, s}, 32'd0);

        // Flush in the middle of a stall on x3.
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cycle(s, i);
        for (int k = 0; k < 5; k++) begin
            drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cycle(s, i);
        end
        drive(1, 3, 1, 0, 0, 0, 0, 1, 0, 0); cycle(s, i);
        check("flush_stall", {31'b0, s}, 32'd0);
        check("flush_issue", {31'b0, i}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(s, i);
        check("flush_hang", {31'b0, hang}, 32'd0);

        // Watchdog: exactly TIMEOUT stall cycles, then hang is sticky.
        for (int k = 0; k < TIMEOUT; k++) begin
            drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cycle(s, i);
            if (k == TIMEOUT - 2) check("wd_not_yet", {31'b0, hang}, 32'd0);
        end
        check("wd_hang", {31'b0, hang}, 32'd1);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 3); cycle(s, i);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cycle(s, i);
        check("wd_issue_in_hung", {31'b0, i}, 32'd1);
        check("wd_sticky", {31'b0, hang}, 32'd1);
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cycle(s, i);
        do_reset();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cycle(s, i);
        check("post_rst_pend_clear", {31'b0, i}, 32'd1);

        // Randomized traffic on a small register window to provoke hazards.
        for (int k = 0; k < 500; k++) begin
            r_a = 5'($urandom_range(0, 7));
            r_b = 5'($urandom_range(0, 7));
            r_d = 5'($urandom_range(0, 7));
            r_r = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 8, r_a, 1'($urandom_range(0, 1)), r_b,
                  1'($urandom_range(0, 1)), r_d, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, r_r);
            cycle(s, i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
